// File: rtl/io_pin_mux_pkg.sv
// Shared definitions for the io_pin_mux pad multiplexer: register map,
// select-field width helper and per-pad configuration record.
package io_pin_mux_pkg;

   // Word register indices on the reg_addr bus
   localparam logic [2:0] REG_SEL  = 3'd0;
   localparam logic [2:0] REG_OD   = 3'd1;
   localparam logic [2:0] REG_FILT = 3'd2;
   localparam logic [2:0] REG_IN   = 3'd3;
   localparam logic [2:0] REG_RISE = 3'd4;
   localparam logic [2:0] REG_FALL = 3'd5;

   // Width of one pad's function-select field; never narrower than one bit
   function automatic int sel_width(input int num_funcs);
      return (num_funcs > 1) ? $clog2(num_funcs) : 1;
   endfunction

   // Per-pad mode bits taken from the OD and FILT registers
   typedef struct packed {
      logic od;
      logic filt;
   } pad_cfg_t;

endpackage

// File: rtl/io_pad_filter.sv
// One pad's input path: 2-FF synchroniser, optional glitch filter and
// edge detection on the resulting func_in bit.
// Optional feature macro: PINMUX_GLITCH_FILTER_EN (adds the filter counter).
module io_pad_filter #(
   parameter int   FILT_W  = 3,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_in,
   input  logic filt_en,
   output logic func_in,
   output logic rise,
   output logic fall
);

   logic sync1;
   logic sync2;
   logic prev;

   // Two-flop synchroniser for the asynchronous pad input
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= RST_VAL;
         sync2 <= RST_VAL;
      end else begin
         sync1 <= pad_in;
         sync2 <= sync1;
      end
   end

`ifdef PINMUX_GLITCH_FILTER_EN
   // Last count before the filtered value is allowed to follow the input
   localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'((2 ** FILT_W) - 2);

   logic [FILT_W-1:0] cnt;
   logic              filt_val;

   // Saturating stability counter; filt_val tracks sync2 while disabled so enabling never glitches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         filt_val <= RST_VAL;
      end else if (!filt_en) begin
         cnt      <= '0;
         filt_val <= sync2;
      end else if (sync2 == filt_val) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt      <= '0;
         filt_val <= sync2;
      end else begin
         cnt <= cnt + FILT_W'(1);
      end
   end

   assign func_in = filt_en ? filt_val : sync2;
`else
   logic unused_filt_en;
   assign unused_filt_en = filt_en;
   assign func_in        = sync2;
`endif

   // Previous func_in value for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= RST_VAL;
      else     prev <= func_in;
   end

   assign rise = func_in & ~prev;
   assign fall = ~func_in & prev;

endmodule

// File: rtl/io_pin_mux.sv
// Pad multiplexer between peripheral functions and chip pads: per-pad
// function select, open-drain mode, synchronised input with sticky edge
// flags and a small word-addressed register interface.
// Optional feature macro: PINMUX_GLITCH_FILTER_EN (per-pad glitch filter, FILT register).
module io_pin_mux
   import io_pin_mux_pkg::*;
#(
   parameter int                    NUM_PADS   = 8,
   parameter int                    NUM_FUNCS  = 4,
   parameter int                    FILT_W     = 3,
   parameter logic [NUM_PADS-1:0]   IN_RST_VAL = '1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          reg_we,
   input  logic                          reg_re,
   input  logic [2:0]                    reg_addr,
   input  logic [31:0]                   reg_wdata,
   output logic [31:0]                   reg_rdata,
   output logic                          reg_ready,
   input  logic [NUM_FUNCS*NUM_PADS-1:0] func_out,
   input  logic [NUM_FUNCS*NUM_PADS-1:0] func_oe,
   output logic [NUM_PADS-1:0]           func_in,
   input  logic [NUM_PADS-1:0]           pad_in,
   output logic [NUM_PADS-1:0]           pad_out,
   output logic [NUM_PADS-1:0]           pad_oe
);

   localparam int SEL_W  = sel_width(NUM_FUNCS);
   localparam int SELV_W = NUM_PADS * SEL_W;

   logic [SELV_W-1:0]   sel_q;
   logic [NUM_PADS-1:0] od_q;
   logic [NUM_PADS-1:0] filt_q;
   logic [NUM_PADS-1:0] rise_q;
   logic [NUM_PADS-1:0] fall_q;
   logic [NUM_PADS-1:0] rise_evt;
   logic [NUM_PADS-1:0] fall_evt;
   logic [NUM_PADS-1:0] rise_clr;
   logic [NUM_PADS-1:0] fall_clr;
   logic [NUM_PADS-1:0] out_d;
   logic [NUM_PADS-1:0] oe_d;
   logic [31:0]         rd_val;
   pad_cfg_t            cfg [NUM_PADS];

   logic unused_wdata;
   assign unused_wdata = ^reg_wdata;

   assign rise_clr = (reg_we && reg_addr == REG_RISE) ? reg_wdata[NUM_PADS-1:0] : '0;
   assign fall_clr = (reg_we && reg_addr == REG_FALL) ? reg_wdata[NUM_PADS-1:0] : '0;

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      logic [SEL_W-1:0] f;
      logic             fo;
      logic             foe;

      assign f = sel_q[p*SEL_W +: SEL_W];

      // Pick the selected function's output and enable; unimplemented selects give 0
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      always_comb begin
         fo  = 1'b0;
         foe = 1'b0;
         for (int i = 0; i < NUM_FUNCS; i++) begin
            if (f == SEL_W'(i)) begin
               fo  = func_out[i*NUM_PADS + p];
               foe = func_oe[i*NUM_PADS + p];
            end
         end
      end

      assign cfg[p]   = '{od: od_q[p], filt: filt_q[p]};
      // Open drain only ever drives low; a high request releases the pad
      assign out_d[p] = cfg[p].od ? 1'b0 : fo;
      assign oe_d[p]  = cfg[p].od ? (foe & ~fo) : foe;

      io_pad_filter #(
         .FILT_W  (FILT_W),
         .RST_VAL (IN_RST_VAL[p])
      ) u_pad (
         .clk     (clk),
         .rst     (rst),
         .pad_in  (pad_in[p]),
         .filt_en (cfg[p].filt),
         .func_in (func_in[p]),
         .rise    (rise_evt[p]),
         .fall    (fall_evt[p])
      );
   end

   // Registered pad drive so a select change never passes through an unrelated function
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pad_out <= '0;
         pad_oe  <= '0;
      end else begin
         pad_out <= out_d;
         pad_oe  <= oe_d;
      end
   end

   // Read mux; unused upper bits and unmapped registers read as zero
   always_comb begin
      rd_val = '0;
      case (reg_addr)
         REG_SEL:  rd_val[SELV_W-1:0]   = sel_q;
         REG_OD:   rd_val[NUM_PADS-1:0] = od_q;
         REG_FILT: rd_val[NUM_PADS-1:0] = filt_q;
         REG_IN:   rd_val[NUM_PADS-1:0] = func_in;
         REG_RISE: rd_val[NUM_PADS-1:0] = rise_q;
         REG_FALL: rd_val[NUM_PADS-1:0] = fall_q;
         default:  rd_val = '0;
      endcase
   end

   // Register file, access handshake and sticky edge flags (set wins over W1C)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q     <= '0;
         od_q      <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         reg_ready <= 1'b0;
         reg_rdata <= '0;
      end else begin
         reg_ready <= reg_we | reg_re;
         if (reg_re) reg_rdata <= rd_val;
         if (reg_we && reg_addr == REG_SEL) sel_q <= reg_wdata[SELV_W-1:0];
         if (reg_we && reg_addr == REG_OD)  od_q  <= reg_wdata[NUM_PADS-1:0];
         rise_q <= (rise_q & ~rise_clr) | rise_evt;
         fall_q <= (fall_q & ~fall_clr) | fall_evt;
      end
   end

`ifdef PINMUX_GLITCH_FILTER_EN
   // Per-pad filter enable register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                filt_q <= '0;
      else if (reg_we && reg_addr == REG_FILT) filt_q <= reg_wdata[NUM_PADS-1:0];
   end
`else
   assign filt_q = '0;
`endif

endmodule

// File: tb/tb_io_pin_mux.sv
// Directed self-checking bench for io_pin_mux (NUM_PADS=8, NUM_FUNCS=4, FILT_W=3).
// Build with PINMUX_GLITCH_FILTER_EN to exercise the glitch filter.
module tb_io_pin_mux;
   import io_pin_mux_pkg::*;

   localparam int NP = 8;
   localparam int NF = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           reg_we;
   logic           reg_re;
   logic [2:0]     reg_addr;
   logic [31:0]    reg_wdata;
   logic [31:0]    reg_rdata;
   logic           reg_ready;
   logic [NF*NP-1:0] func_out;
   logic [NF*NP-1:0] func_oe;
   logic [NP-1:0]  func_in;
   logic [NP-1:0]  pad_in;
   logic [NP-1:0]  pad_out;
   logic [NP-1:0]  pad_oe;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   io_pin_mux #(
      .NUM_PADS   (NP),
      .NUM_FUNCS  (NF),
      .FILT_W     (3),
      .IN_RST_VAL ('1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .reg_ready (reg_ready),
      .func_out  (func_out),
      .func_oe   (func_oe),
      .func_in   (func_in),
      .pad_in    (pad_in),
      .pad_out   (pad_out),
      .pad_oe    (pad_oe)
   );

   // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_we = 1'b0; reg_wdata = '0;
   endtask

   task automatic reg_read(input logic [2:0] a);
      reg_re = 1'b1; reg_addr = a;
      tick();
      reg_re = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; reg_we = 0; reg_re = 0; reg_addr = '0; reg_wdata = '0;
      func_out = '0; func_oe = '0; pad_in = '0;
      tick(); tick();
      vec_cnt++; if (pad_oe !== 8'h00) begin err_cnt++; $display("FAIL reset_pad_oe: got %h want %h", pad_oe, 8'h00); end
      vec_cnt++; if (pad_out !== 8'h00) begin err_cnt++; $display("FAIL reset_pad_out: got %h want %h", pad_out, 8'h00); end
      vec_cnt++; if (func_in !== 8'hFF) begin err_cnt++; $display("FAIL reset_func_in: got %h want %h", func_in, 8'hFF); end
      vec_cnt++; if ({reg_ready, reg_rdata} !== 33'h0) begin err_cnt++; $display("FAIL reset_reg: got %b/%h want 0/0", reg_ready, reg_rdata); end
      rst = 1'b0;
      tick();
      vec_cnt++; if (func_in !== 8'hFF) begin err_cnt++; $display("FAIL sync_lat1: got %h want %h", func_in, 8'hFF); end
      tick();
      vec_cnt++; if (func_in !== 8'h00) begin err_cnt++; $display("FAIL sync_lat2: got %h want %h", func_in, 8'h00); end
      tick();
      reg_read(REG_FALL);
      vec_cnt++; if (reg_rdata !== 32'hFF) begin err_cnt++; $display("FAIL fall_after_reset: got %h want %h", reg_rdata, 32'hFF); end
      vec_cnt++; if (reg_ready !== 1'b1) begin err_cnt++; $display("FAIL ready_pulse: got %b want 1", reg_ready); end
      tick();
      vec_cnt++; if (reg_ready !== 1'b0) begin err_cnt++; $display("FAIL ready_drop: got %b want 0", reg_ready); end
      reg_read(REG_RISE);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL rise_after_reset: got %h want %h", reg_rdata, 32'h0); end
      reg_write(REG_FALL, 32'hFF);
      reg_read(REG_FALL);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL fall_w1c: got %h want %h", reg_rdata, 32'h0); end
   endtask

   task automatic test_sel();
      func_out = 32'h0000_0200; func_oe = 32'h0000_0200;
      reg_write(REG_SEL, 32'h0000_0004);
      vec_cnt++; if (pad_oe !== 8'h00) begin err_cnt++; $display("FAIL sel_early: got %h want %h", pad_oe, 8'h00); end
      tick();
      vec_cnt++; if ({pad_out, pad_oe} !== 16'h0202) begin err_cnt++; $display("FAIL sel_pad1_func1: got %h want %h", {pad_out, pad_oe}, 16'h0202); end
      func_out = 32'h0000_02A5; func_oe = 32'h0000_02FF;
      tick();
      vec_cnt++; if ({pad_out, pad_oe} !== 16'hA7FF) begin err_cnt++; $display("FAIL sel_mixed: got %h want %h", {pad_out, pad_oe}, 16'hA7FF); end
      func_out = 32'h3C00_02A5; func_oe = 32'h0F00_02FF;
      reg_write(REG_SEL, 32'h0000_FFFF);
      tick();
      vec_cnt++; if ({pad_out, pad_oe} !== 16'h3C0F) begin err_cnt++; $display("FAIL sel_all_func3: got %h want %h", {pad_out, pad_oe}, 16'h3C0F); end
      reg_read(REG_SEL);
      vec_cnt++; if (reg_rdata !== 32'h0000_FFFF) begin err_cnt++; $display("FAIL sel_readback: got %h want %h", reg_rdata, 32'h0000_FFFF); end
      reg_write(REG_SEL, 32'h0);
      func_out = '0; func_oe = '0;
      tick();
   endtask

   task automatic test_od();
      func_out = 32'h0; func_oe = 32'h0000_0001;
      reg_write(REG_OD, 32'hFFFF_FF01);
      tick();
      vec_cnt++; if ({pad_out, pad_oe} !== 16'h0001) begin err_cnt++; $display("FAIL od_drive_low: got %h want %h", {pad_out, pad_oe}, 16'h0001); end
      func_out = 32'h0000_0001;
      tick();
      vec_cnt++; if ({pad_out, pad_oe} !== 16'h0000) begin err_cnt++; $display("FAIL od_release: got %h want %h", {pad_out, pad_oe}, 16'h0000); end
      reg_read(REG_OD);
      vec_cnt++; if (reg_rdata !== 32'h01) begin err_cnt++; $display("FAIL od_readback: got %h want %h", reg_rdata, 32'h01); end
      reg_write(REG_OD, 32'h0);
      tick();
      vec_cnt++; if ({pad_out, pad_oe} !== 16'h0101) begin err_cnt++; $display("FAIL pushpull_high: got %h want %h", {pad_out, pad_oe}, 16'h0101); end
      func_out = '0; func_oe = '0;
      tick();
   endtask

   task automatic test_edges();
      pad_in[2] = 1'b1;
      tick();
      vec_cnt++; if (func_in !== 8'h00) begin err_cnt++; $display("FAIL edge_lat1: got %h want %h", func_in, 8'h00); end
      tick();
      vec_cnt++; if (func_in !== 8'h04) begin err_cnt++; $display("FAIL edge_lat2: got %h want %h", func_in, 8'h04); end
      tick();
      reg_read(REG_RISE);
      vec_cnt++; if (reg_rdata !== 32'h04) begin err_cnt++; $display("FAIL rise_set: got %h want %h", reg_rdata, 32'h04); end
      reg_read(REG_IN);
      vec_cnt++; if (reg_rdata !== 32'h04) begin err_cnt++; $display("FAIL in_read: got %h want %h", reg_rdata, 32'h04); end
      reg_write(REG_RISE, 32'h04);
      reg_read(REG_RISE);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL rise_w1c: got %h want %h", reg_rdata, 32'h0); end
      // Clear lands in the same cycle as the pad5 rising edge
      pad_in[5] = 1'b1;
      tick(); tick();
      reg_write(REG_RISE, 32'h20);
      reg_read(REG_RISE);
      vec_cnt++; if (reg_rdata !== 32'h20) begin err_cnt++; $display("FAIL set_wins: got %h want %h", reg_rdata, 32'h20); end
      reg_write(REG_OD, 32'h0);
      vec_cnt++; if ({reg_ready, reg_rdata} !== 33'h1_0000_0020) begin err_cnt++; $display("FAIL rdata_hold: got %b/%h want 1/20", reg_ready, reg_rdata); end
      reg_write(REG_RISE, 32'h20);
      pad_in[2] = 1'b0;
      tick(); tick(); tick();
      reg_we = 1'b1; reg_re = 1'b1; reg_addr = REG_FALL; reg_wdata = 32'h04;
      tick();
      reg_we = 1'b0; reg_re = 1'b0;
      vec_cnt++; if (reg_rdata !== 32'h04) begin err_cnt++; $display("FAIL we_re_prewrite: got %h want %h", reg_rdata, 32'h04); end
      reg_read(REG_FALL);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL we_re_cleared: got %h want %h", reg_rdata, 32'h0); end
      reg_write(3'd6, 32'hFFFF_FFFF);
      reg_read(3'd6);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL reg6_zero: got %h want %h", reg_rdata, 32'h0); end
   endtask

   task automatic test_filter();
`ifdef PINMUX_GLITCH_FILTER_EN
      logic seen;
      reg_write(REG_FILT, 32'h08);
      reg_read(REG_FILT);
      vec_cnt++; if (reg_rdata !== 32'h08) begin err_cnt++; $display("FAIL filt_readback: got %h want %h", reg_rdata, 32'h08); end
      seen = 1'b0;
      pad_in[3] = 1'b1;
      for (int i = 0; i < 5; i++) begin tick(); seen = seen | func_in[3]; end
      pad_in[3] = 1'b0;
      for (int i = 0; i < 12; i++) begin tick(); seen = seen | func_in[3]; end
      vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL filt_short_pulse: got %b want 0", seen); end
      pad_in[3] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 8) begin
            vec_cnt++; if (func_in[3] !== 1'b0) begin err_cnt++; $display("FAIL filt_lat8: got %b want 0", func_in[3]); end
         end
         if (i == 9) begin
            vec_cnt++; if (func_in !== 8'h28) begin err_cnt++; $display("FAIL filt_lat9: got %h want %h", func_in, 8'h28); end
         end
      end
      pad_in[3] = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      vec_cnt++; if (func_in !== 8'h20) begin err_cnt++; $display("FAIL filt_return: got %h want %h", func_in, 8'h20); end
`else
      reg_write(REG_FILT, 32'hFF);
      reg_read(REG_FILT);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL filt_absent: got %h want %h", reg_rdata, 32'h0); end
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_in;
      func_out = 32'h0000_00FF; func_oe = 32'h0000_00FF;
      reg_write(REG_OD, 32'h80);
      tick();
      vec_cnt++; if ({pad_out, pad_oe} !== 16'h7F7F) begin err_cnt++; $display("FAIL pre_reset_drive: got %h want %h", {pad_out, pad_oe}, 16'h7F7F); end
`ifdef PINMUX_GLITCH_FILTER_EN
      reg_write(REG_FILT, 32'h08);
      exp_in = 32'h24;
`else
      exp_in = 32'h2C;
`endif
      pad_in = 8'h2C;
      for (int i = 0; i < 5; i++) tick();
      reg_read(REG_IN);
      vec_cnt++; if (reg_rdata !== exp_in) begin err_cnt++; $display("FAIL pre_reset_in: got %h want %h", reg_rdata, exp_in); end
      #2 rst = 1'b1;
      #1;
      vec_cnt++; if ({pad_out, pad_oe} !== 16'h0000) begin err_cnt++; $display("FAIL midrst_pads: got %h want %h", {pad_out, pad_oe}, 16'h0000); end
      vec_cnt++; if ({reg_ready, reg_rdata} !== 33'h0) begin err_cnt++; $display("FAIL midrst_reg: got %b/%h want 0/0", reg_ready, reg_rdata); end
      vec_cnt++; if (func_in !== 8'hFF) begin err_cnt++; $display("FAIL midrst_func_in: got %h want %h", func_in, 8'hFF); end
      tick();
      rst = 1'b0;
      func_out = '0; func_oe = '0;
      tick(); tick();
      vec_cnt++; if (func_in !== 8'h2C) begin err_cnt++; $display("FAIL postrst_func_in: got %h want %h", func_in, 8'h2C); end
      tick();
      reg_read(REG_RISE);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL postrst_rise: got %h want %h", reg_rdata, 32'h0); end
      reg_read(REG_FALL);
      vec_cnt++; if (reg_rdata !== 32'hD3) begin err_cnt++; $display("FAIL postrst_fall: got %h want %h", reg_rdata, 32'hD3); end
      reg_read(REG_OD);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL postrst_od: got %h want %h", reg_rdata, 32'h0); end
      reg_read(REG_FILT);
      vec_cnt++; if (reg_rdata !== 32'h0) begin err_cnt++; $display("FAIL postrst_filt: got %h want %h", reg_rdata, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_sel();
      test_od();
      test_edges();
      test_filter();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
